// File: rtl/fcl_fp_feeder.sv
// rtl/fcl_fp_feeder.sv - activation/weight feeder for a PE array
// Streams activations, fetches weight rows, sequences accumulate control and latches the result vector.
module fcl_fp_feeder #(
  parameter int FP_WIDTH    = 16,
  parameter int FP_PARALLEL = 4,
  parameter int LEN_WIDTH   = 8,
  localparam int SH_W       = $clog2(4*FP_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            len,
  input  logic [SH_W-1:0]                 shift_in,
  output logic                            busy,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [FP_WIDTH-1:0]      in_data,
  output logic                            w_rd,
  output logic [LEN_WIDTH-1:0]            w_addr,
  input  logic [FP_PARALLEL*FP_WIDTH-1:0] w_rdata,
  output logic [FP_WIDTH-1:0]             pe_input,
  output logic [FP_PARALLEL*FP_WIDTH-1:0] pe_w,
  output logic                            pe_clr_n,
  output logic [SH_W-1:0]                 pe_shift,
  input  logic [FP_PARALLEL*FP_WIDTH-1:0] pe_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FP_PARALLEL*FP_WIDTH-1:0] out_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [LEN_WIDTH-1:0]             len_q, len_d;
  logic [LEN_WIDTH-1:0]             k_q, k_d;
  logic [SH_W-1:0]                  shift_q, shift_d;
  logic signed [FP_WIDTH-1:0]       data_q, data_d;
  logic                             issue_q, issue_d;
  logic                             started_q, started_d;
  logic [FP_PARALLEL*FP_WIDTH-1:0]  out_q, out_d;
  logic                             accept;

  assign in_ready = (state_q == S_RUN) && (k_q < len_q);
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    k_d       = k_q;
    shift_d   = shift_q;
    data_d    = data_q;
    started_d = started_q;
    out_d     = out_q;
    issue_d   = accept;
    case (state_q)
      S_IDLE: begin
        started_d = 1'b0;
        if (start && (len != '0)) begin
          state_d = S_RUN;
          len_d   = len;
          shift_d = shift_in;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          k_d    = k_q + LEN_WIDTH'(1);
          data_d = in_data;
        end
        // Once element 0 has been loaded, every later issue accumulates.
        if (issue_q) started_d = 1'b1;
        if (issue_q && (k_q == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        out_d   = pe_result;
        state_d = S_OUT;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      k_q       <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      issue_q   <= 1'b0;
      started_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      k_q       <= k_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      issue_q   <= issue_d;
      started_q <= started_d;
      out_q     <= out_d;
    end
  end

  // Non-issue cycles drive zero operands so the enable-less array holds its sum.
  assign busy      = (state_q != S_IDLE);
  assign w_rd      = accept;
  assign w_addr    = accept ? k_q : '0;
  assign pe_input  = issue_q ? data_q : '0;
  assign pe_w      = issue_q ? w_rdata : '0;
  assign pe_clr_n  = started_q;
  assign pe_shift  = shift_q;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_q;

endmodule

// File: tb/tb_fcl_fp_feeder.sv
// tb/tb_fcl_fp_feeder.sv - directed bench for fcl_fp_feeder
// Weight memory and PE array are modelled behaviourally around the feeder.
module tb_fcl_fp_feeder;
  localparam int FPW  = 16;
  localparam int FPP  = 4;
  localparam int LW   = 8;
  localparam int SH_W = $clog2(4*FPW);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [LW-1:0]      len;
  logic [SH_W-1:0]    shift_in;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [FPW-1:0]     in_data;
  logic               w_rd;
  logic [LW-1:0]      w_addr;
  logic [FPP*FPW-1:0] w_rdata;
  logic [FPW-1:0]     pe_input;
  logic [FPP*FPW-1:0] pe_w;
  logic               pe_clr_n;
  logic [SH_W-1:0]    pe_shift;
  logic [FPP*FPW-1:0] pe_result;
  logic               out_valid;
  logic               out_ready;
  logic [FPP*FPW-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int din [8];
  logic [FPP*FPW-1:0] mem [256];
  longint acc [FPP];

  fcl_fp_feeder #(.FP_WIDTH(FPW), .FP_PARALLEL(FPP), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .shift_in(shift_in),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .pe_input(pe_input), .pe_w(pe_w), .pe_clr_n(pe_clr_n), .pe_shift(pe_shift),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (w_rd) w_rdata <= mem[w_addr];

  // Accumulator deliberately ignores rst so a stale sum is only cleared via pe_clr_n.
  initial for (int l = 0; l < FPP; l++) acc[l] = 0;
  always @(posedge clk) begin
    for (int l = 0; l < FPP; l++) begin
      longint p;
      p = longint'($signed(pe_input)) * longint'($signed(pe_w[l*FPW +: FPW]));
      acc[l] <= pe_clr_n ? acc[l] + p : p;
    end
  end
  always_comb begin
    pe_result = '0;
    for (int l = 0; l < FPP; l++) begin
      longint t;
      t = acc[l] >>> pe_shift;
      pe_result[l*FPW +: FPW] = t[FPW-1:0];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_in_ready"}, 64'(in_ready), 0);
    check({tag, "_w_rd"}, 64'(w_rd), 0);
    check({tag, "_w_addr"}, 64'(w_addr), 0);
    check({tag, "_pe_input"}, 64'(pe_input), 0);
    check({tag, "_pe_w"}, 64'(pe_w), 0);
    check({tag, "_pe_clr_n"}, 64'(pe_clr_n), 0);
    check({tag, "_pe_shift"}, 64'(pe_shift), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_out_data"}, 64'(out_data), 0);
  endtask

  task automatic run_job(input int n, input int sh, input int b_after, input int b_cnt, input string tag);
    int idx = 0;
    int bub = 0;
    int last = 0;
    int t = 0;
    logic prev_acc = 1'b0;
    logic acc_now;
    @(negedge clk);
    start = 1'b1; len = LW'(n); shift_in = SH_W'(sh);
    @(negedge clk);
    start = 1'b0;
    while (idx < n && t < 200) begin
      in_valid = !(idx == b_after && bub < b_cnt);
      in_data  = FPW'(din[idx]);
      #1;
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        check({tag, "_w_rd"}, 64'(w_rd), 1);
        check({tag, "_w_addr"}, 64'(w_addr), 64'(idx));
        last = cyc;
        idx++;
      end else if (!in_valid) begin
        if (!prev_acc) check({tag, "_bubble_pe_input"}, 64'(pe_input), 0);
        bub++;
      end
      prev_acc = acc_now;
      t++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (idx < n) check({tag, "_accept_timeout"}, 64'(idx), 64'(n));
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_latency"}, 64'(cyc - last), 3);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ack_out_valid"}, 64'(out_valid), 0);
    check({tag, "_ack_busy"}, 64'(busy), 0);
  endtask

  initial begin
    logic [FPP*FPW-1:0] held;
    rst = 1'b1; start = 1'b0; len = '0; shift_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int a = 0; a < 256; a++)
      for (int l = 0; l < FPP; l++) mem[a][l*FPW +: FPW] = FPW'(l + 1);
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // len=3, back-to-back 2,3,4 against weights lane+1
    din[0] = 2; din[1] = 3; din[2] = 4;
    run_job(3, 0, 99, 0, "a");
    check("a_lane0", 64'(out_data[0*FPW +: FPW]), 9);
    check("a_lane1", 64'(out_data[1*FPW +: FPW]), 18);
    check("a_lane3", 64'(out_data[3*FPW +: FPW]), 36);
    ack("a");

    run_job(3, 0, 1, 2, "b");
    check("b_lane0", 64'(out_data[0*FPW +: FPW]), 9);
    check("b_lane2", 64'(out_data[2*FPW +: FPW]), 27);
    ack("b");

    // len=1, 16*16 >> 4 on lane0; lane1 is 16*2 >> 4
    mem[0][0 +: FPW] = 16'd16;
    din[0] = 16;
    run_job(1, 4, 99, 0, "c");
    check("c_lane0", 64'(out_data[0*FPW +: FPW]), 16);
    check("c_lane1", 64'(out_data[1*FPW +: FPW]), 2);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd3; shift_in = '0;
      #1;
      check("hold_out_valid", 64'(out_valid), 1);
      check("hold_out_data", 64'(out_data), 64'(held));
      @(negedge clk);
    end
    start = 1'b0;
    ack("c");
    check("c_start_ignored_in_ready", 64'(in_ready), 0);
    mem[0][0 +: FPW] = 16'd1;

    // zero-length start must leave the block idle
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("len0_busy", 64'(busy), 0);
      check("len0_w_rd", 64'(w_rd), 0);
      check("len0_out_valid", 64'(out_valid), 0);
      @(negedge clk);
    end

    // abort a len=4 job after two accepts
    din[0] = 7; din[1] = 9;
    start = 1'b1; len = 8'd4; shift_in = 6'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = FPW'(din[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_out_valid", 64'(out_valid), 0);
      @(negedge clk);
    end

    din[0] = 5; din[1] = 6;
    run_job(2, 0, 99, 0, "d");
    check("d_lane0", 64'(out_data[0*FPW +: FPW]), 11);
    check("d_lane1", 64'(out_data[1*FPW +: FPW]), 22);
    ack("d");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fcl_fp_feeder.md
FCL_FP_FEEDER -- requirements
Module: fcl_fp_feeder

Interface
REQ-001 Parameter FP_WIDTH, default 16: activation, weight and result lane width.
REQ-002 Parameter FP_PARALLEL, default 4: number of PE lanes in the downstream array.
REQ-003 Parameter LEN_WIDTH, default 8: width of the vector-length and weight-address fields.
REQ-004 clk  input  1: single clock; all state on rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 start  input  1: job start pulse; sampled only in IDLE.
REQ-007 len  input  LEN_WIDTH: element count of the job; sampled with start.
REQ-008 shift_in  input  $clog2(4*FP_WIDTH): result shift amount; sampled with start.
REQ-009 busy  output  1: high in every state except IDLE.
REQ-010 in_valid / in_ready  input / output  1: activation stream handshake.
REQ-011 in_data  input  FP_WIDTH (signed): activation element.
REQ-012 w_rd  output  1: weight memory read strobe.
REQ-013 w_addr  output  LEN_WIDTH: weight row address.
REQ-014 w_rdata  input  FP_PARALLEL*FP_WIDTH: weight row; valid exactly 1 cycle after w_rd.
REQ-015 pe_input  output  FP_WIDTH: activation to the array.
REQ-016 pe_w  output  FP_PARALLEL*FP_WIDTH: weights to the array.
REQ-017 pe_clr_n  output  1: array accumulate control; 0 = load product, 1 = accumulate.
REQ-018 pe_shift  output  $clog2(4*FP_WIDTH): shift to the array.
REQ-019 pe_result  input  FP_PARALLEL*FP_WIDTH: combinational array outputs.
REQ-020 out_valid / out_ready  output / input  1: result handshake.
REQ-021 out_data  output  FP_PARALLEL*FP_WIDTH: latched result vector.

Function
REQ-022 FSM states: IDLE, RUN, DRAIN, OUT.
REQ-023 Transition IDLE->RUN on start with len!=0; latch len, shift_in into pe_shift, clear element counter k.
REQ-024 A start with len==0 shall be ignored; the FSM stays in IDLE.
REQ-025 A start outside IDLE shall be ignored.
REQ-026 in_ready = (state==RUN) && (k < len).
REQ-027 On an accept (in_valid && in_ready): w_rd=1, w_addr=k, register in_data, k<=k+1.
REQ-028 Stage-2 issue, the cycle after an accept: pe_input = registered data; pe_w = w_rdata.
REQ-029 Stage-2 issue: pe_clr_n=0 if the element is element 0 of the job, else 1.
REQ-030 In non-issue cycles, pe_input=0 and pe_w=0 so the array accumulator holds; the array has no enable.
REQ-031 pe_clr_n=0 in IDLE and in RUN before the first issue; pe_clr_n=1 afterwards until return to IDLE.
REQ-032 RUN->DRAIN in the cycle in which the last element (k==len) is issued to the array.
REQ-033 DRAIN lasts 1 cycle; at its end, latch pe_result into out_data; go to OUT.
REQ-034 In OUT, out_valid=1; out_data stays stable until out_ready.
REQ-035 OUT->IDLE on out_ready; out_valid drops the next cycle.
REQ-036 Latency: last accept at cycle t gives out_valid at cycle t+3.
REQ-037 Throughput: 1 element/cycle with in_valid held high; bubbles add 1 cycle each.
REQ-038 The counter shall not wrap; len = 2^LEN_WIDTH-1 is the maximum job.
REQ-039 The block shall perform no arithmetic on data; the shift is applied only in the array.

Reset
REQ-040 While rst=1: state=IDLE, k=0, busy=0, in_ready=0, w_rd=0, w_addr=0.
REQ-041 While rst=1: pe_input=0, pe_w=0, pe_clr_n=0, pe_shift=0, out_valid=0, out_data=0.
REQ-042 Reset mid-job aborts immediately; no out_valid is produced for the aborted job.

Verification
REQ-043 len=3, in_data 2,3,4 back-to-back, lane0 weights 1,1,1, shift 0 -> lane0 out_data=9, out_valid at last accept+3.
REQ-044 Same job with in_valid low for 2 cycles after element 1 -> pe_input=0 during bubbles; result still 9.
REQ-045 len=1, in=16, w=16, shift=4 -> out_data lane=16.
REQ-046 out_ready held low 5 cycles -> out_valid and out_data stable; start pulses in that window ignored.
REQ-047 rst asserted after 2 of 4 elements -> all outputs zero; next len=2 job produces a correct, uncontaminated result.
REQ-048 start with len=0 -> busy stays 0; no w_rd; no out_valid.
